// File: rtl/ram2p_arb_pkg.sv
// Shared types and default sizing for the arbitrated two-port RAM block.
package ram2p_arb_pkg;

  localparam int AWID_DEF = 8;
  localparam int DWID_DEF = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ram2p.sv
// Dual-port RAM: synchronous writes on both ports, asynchronous read on port A.
module ram2p
  import ram2p_arb_pkg::*;
#(
  parameter int AWID  = AWID_DEF,
  parameter int DEPTH = 2**AWID,
  parameter int DWID  = DWID_DEF
) (
  input  logic            clk,
  input  logic            we_a,
  input  logic [AWID-1:0] addr_a,
  input  logic [DWID-1:0] wdat_a,
  output logic [DWID-1:0] rdat_a,
  input  logic            we_b,
  input  logic [AWID-1:0] addr_b,
  input  logic [DWID-1:0] wdat_b
);

  logic [DWID-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdat_a;
    if (we_b) mem[addr_b] <= wdat_b;
  end

  assign rdat_a = mem[addr_a];

endmodule

// File: rtl/ram2p_arb.sv
// Two-requester round-robin front end for ram2p; zero-fills the array after reset.
//   state   | meaning
//   ST_INIT | writing 0 to one address per cycle, requests held off
//   ST_RUN  | arbitrating requesters onto RAM port A
module ram2p_arb
  import ram2p_arb_pkg::*;
#(
  parameter int AWID  = AWID_DEF,
  parameter int DEPTH = 2**AWID,
  parameter int DWID  = DWID_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req0,
  input  logic            i_req1,
  input  logic            i_we0,
  input  logic            i_we1,
  input  logic [AWID-1:0] i_addr0,
  input  logic [AWID-1:0] i_addr1,
  input  logic [DWID-1:0] i_dat0,
  input  logic [DWID-1:0] i_dat1,
  output logic            o_gnt0,
  output logic            o_gnt1,
  output logic            o_rvalid0,
  output logic            o_rvalid1,
  output logic [DWID-1:0] o_rdat,
  output logic            o_busy
);

  localparam logic [AWID:0] DEPTH_W = (AWID+1)'(DEPTH);
  localparam logic [AWID:0] LAST_W  = (AWID+1)'(DEPTH - 1);

  state_t          state;
  logic [AWID-1:0] init_addr;
  logic            last_gnt1;
  logic            run;
  logic            pick1;
  logic            acc_we;
  logic            acc_in_range;
  logic [AWID-1:0] acc_addr;
  logic [DWID-1:0] acc_dat;
  logic            ram_we;
  logic [AWID-1:0] ram_addr;
  logic [DWID-1:0] ram_wdat;
  logic [DWID-1:0] ram_rdat;

  assign run = (state == ST_RUN);

  // Source 1 wins when alone, or on a tie when source 0 was granted last.
  assign pick1  = i_req1 & (~i_req0 | ~last_gnt1);
  assign o_gnt0 = run & i_req0 & ~pick1;
  assign o_gnt1 = run & pick1;

  assign acc_we       = pick1 ? i_we1   : i_we0;
  assign acc_addr     = pick1 ? i_addr1 : i_addr0;
  assign acc_dat      = pick1 ? i_dat1  : i_dat0;
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_W);

  assign ram_we   = run ? ((o_gnt0 | o_gnt1) & acc_we & acc_in_range) : 1'b1;
  assign ram_addr = run ? acc_addr : init_addr;
  assign ram_wdat = run ? acc_dat  : '0;

  ram2p #(
    .AWID  (AWID),
    .DEPTH (DEPTH),
    .DWID  (DWID)
  ) u_ram (
    .clk    (clk),
    .we_a   (ram_we),
    .addr_a (ram_addr),
    .wdat_a (ram_wdat),
    .rdat_a (ram_rdat),
    .we_b   (1'b0),
    .addr_b ('0),
    .wdat_b ('0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
      last_gnt1 <= 1'b1;
      o_busy    <= 1'b1;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdat    <= '0;
    end else begin
      o_rvalid0 <= o_gnt0 & ~i_we0;
      o_rvalid1 <= o_gnt1 & ~i_we1;
      case (state)
        ST_INIT: begin
          init_addr <= init_addr + 1'b1;
          if ({1'b0, init_addr} == LAST_W) begin
            state  <= ST_RUN;
            o_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (o_gnt0 | o_gnt1) begin
            last_gnt1 <= o_gnt1;
            if (!acc_we) o_rdat <= acc_in_range ? ram_rdat : '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram2p_arb.sv
// Directed bench for ram2p_arb with a reference memory model and read scoreboard.
module tb_ram2p_arb;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] dat0, dat1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [15:0] rdat;

  int n_vec = 0;
  int n_mis = 0;

  logic [15:0] m_mem [256];
  logic        m_run;
  logic        m_last1;
  logic [15:0] m_rdat;
  logic [16:0] sb [$];

  ram2p_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req0    (req0),
    .i_req1    (req1),
    .i_we0     (we0),
    .i_we1     (we1),
    .i_addr0   (addr0),
    .i_addr1   (addr1),
    .i_dat0    (dat0),
    .i_dat1    (dat1),
    .o_gnt0    (gnt0),
    .o_gnt1    (gnt1),
    .o_rvalid0 (rvalid0),
    .o_rvalid1 (rvalid1),
    .o_rdat    (rdat),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
    req0 = r; we0 = w; addr0 = a; dat0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
    req1 = r; we1 = w; addr1 = a; dat1 = d;
  endtask

  task automatic m_reset();
    m_run   = 1'b0;
    m_last1 = 1'b1;
    m_rdat  = '0;
    sb.delete();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  // One RUN cycle: grants checked mid-cycle, read results checked after the edge.
  task automatic tick(input string tag);
    logic        eg0, eg1;
    logic [16:0] e;
    bit          rd;
    @(negedge clk);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (m_run) begin
      if (req0 && req1) begin
        if (m_last1) eg0 = 1'b1;
        else         eg1 = 1'b1;
      end else begin
        eg0 = req0;
        eg1 = req1;
      end
    end
    chk({tag, ".gnt0"}, gnt0, eg0);
    chk({tag, ".gnt1"}, gnt1, eg1);
    rd = 0;
    if (eg0) begin
      if (we0) m_mem[addr0] = dat0;
      else begin sb.push_back({1'b0, m_mem[addr0]}); rd = 1; end
    end
    if (eg1) begin
      if (we1) m_mem[addr1] = dat1;
      else begin sb.push_back({1'b1, m_mem[addr1]}); rd = 1; end
    end
    if (eg0 || eg1) m_last1 = eg1;
    @(posedge clk);
    #1;
    if (rd) begin
      e = sb.pop_front();
      chk({tag, ".rv0"}, rvalid0, !e[16]);
      chk({tag, ".rv1"}, rvalid1, e[16]);
      chk({tag, ".rdat"}, rdat, e[15:0]);
      m_rdat = e[15:0];
    end else begin
      chk({tag, ".rv0"}, rvalid0, 1'b0);
      chk({tag, ".rv1"}, rvalid1, 1'b0);
      chk({tag, ".hold"}, rdat, m_rdat);
    end
  endtask

  // Counts busy cycles (bounded); stop_at > 0 leaves early with init partly done.
  task automatic wait_init(input string tag, input int stop_at);
    int cnt = 0;
    bit bad = 0;
    while (busy === 1'b1 && cnt < 1000 && (stop_at == 0 || cnt < stop_at)) begin
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) bad = 1;
      cnt++;
      @(posedge clk);
      #1;
    end
    chk({tag, ".len"}, cnt, (stop_at == 0) ? 256 : stop_at);
    chk({tag, ".quiet"}, bad, 0);
    if (stop_at == 0) chk({tag, ".busy_low"}, busy, 1'b0);
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 8'h7F, 16'h0);
    set1(1'b0, 1'b0, 8'h00, 16'h0);
    m_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b1);
    chk("rst.rv0", rvalid0, 1'b0);
    chk("rst.rv1", rvalid1, 1'b0);
    chk("rst.rdat", rdat, 16'h0);
    chk("rst.gnt0", gnt0, 1'b0);

    rst_n = 1'b1;
    wait_init("init1", 0);
    m_run = 1'b1;
    tick("rd7f");

    set0(1'b1, 1'b1, 8'h05, 16'hBEEF);
    tick("wr05");
    set0(1'b1, 1'b0, 8'h05, 16'h0);
    tick("rd05");

    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b1, 8'(i), 16'(16'h10 + i));
      tick("pre");
    end
    set0(1'b0, 1'b0, 8'h00, 16'h0);
    set1(1'b1, 1'b1, 8'h30, 16'hA5A5);
    tick("wr30s1");
    set1(1'b0, 1'b0, 8'h00, 16'h0);
    set0(1'b1, 1'b0, 8'h30, 16'h0);
    tick("rd30s0");
    set0(1'b0, 1'b0, 8'h00, 16'h0);
    set1(1'b1, 1'b0, 8'h30, 16'h0);
    tick("rd30s1");

    set0(1'b1, 1'b0, 8'h05, 16'h0);
    set1(1'b1, 1'b0, 8'h02, 16'h0);
    repeat (6) tick("tie");

    set0(1'b0, 1'b0, 8'h00, 16'h0);
    for (int i = 0; i < 4; i++) begin
      set1(1'b1, 1'b0, 8'(i), 16'h0);
      tick("s1b2b");
    end
    set1(1'b0, 1'b0, 8'h00, 16'h0);
    repeat (2) tick("idle");

    // Reset while init has reached address 100.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    rst_n = 1'b1;
    wait_init("init2a", 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midinit.busy", busy, 1'b1);
    chk("midinit.rdat", rdat, 16'h0);
    m_reset();
    rst_n = 1'b1;
    wait_init("init2b", 0);
    m_run = 1'b1;

    set0(1'b1, 1'b1, 8'h05, 16'h5A5A);
    tick("wr05b");

    // Reset lands on the edge that would return a granted read.
    set0(1'b1, 1'b0, 8'h05, 16'h0);
    @(negedge clk);
    chk("midrun.gnt0", gnt0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun.rv0", rvalid0, 1'b0);
    chk("midrun.busy", busy, 1'b1);
    m_reset();
    set0(1'b1, 1'b0, 8'h00, 16'h0);
    rst_n = 1'b1;
    wait_init("init3", 0);
    m_run = 1'b1;
    tick("rd00");
    set0(1'b1, 1'b0, 8'h05, 16'h0);
    tick("rd05clr");
    set0(1'b0, 1'b0, 8'h00, 16'h0);
    tick("end");

    chk("sb.empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
